// File: rtl/sprite_palette_arbiter.sv
// sprite_palette_arbiter: round-robin share of one palette lookup between two sprite pipelines.
//   Clk, Reset_n (async active-low)
//   req_valid/req_index/req_tag -> req_ready : two requesters, bit/slice 0 = P1, 1 = P2
//   pal_index -> pal_rgb                     : shared combinational palette
//   out_valid/out_ready, out_rgb, out_tag, out_src, out_transparent : registered pixel
//   Optional PAL_ARB_STATS_EN: stats_clr, grant_cnt_p1, grant_cnt_p2 per-requester transfer counters
module sprite_palette_arbiter #(
  parameter int IDX_W = 5,
  parameter int RGB_W = 12,
  parameter int TAG_W = 10,
  parameter logic [RGB_W-1:0] TRANSPARENT_RGB = 12'hF0F
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [1:0]         req_valid,
  input  logic [2*IDX_W-1:0] req_index,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic [1:0]         req_ready,
  output logic [IDX_W-1:0]   pal_index,
  input  logic [RGB_W-1:0]   pal_rgb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RGB_W-1:0]   out_rgb,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_src,
  output logic               out_transparent
`ifdef PAL_ARB_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [15:0]        grant_cnt_p1,
  output logic [15:0]        grant_cnt_p2
`endif
);
  logic             out_valid_q, out_valid_d;
  logic [RGB_W-1:0] out_rgb_q, out_rgb_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_src_q, out_src_d;
  logic             out_transparent_q, out_transparent_d;
  logic             last_grant_q, last_grant_d;
  logic             slot_free, gnt_any, gnt_id;
  logic [IDX_W-1:0] gnt_index;
  logic [TAG_W-1:0] gnt_tag;
  always_comb begin
    slot_free         = !out_valid_q || out_ready;
    gnt_any           = slot_free && (|req_valid);
    // on contention the requester not granted last wins; otherwise the lone valid one
    gnt_id            = (&req_valid) ? !last_grant_q : req_valid[1];
    gnt_index         = gnt_id ? req_index[2*IDX_W-1:IDX_W] : req_index[IDX_W-1:0];
    gnt_tag           = gnt_id ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
    // reset gating kept off the flop inputs so Reset_n only ever acts asynchronously there
    req_ready         = (gnt_any && Reset_n) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    pal_index         = (gnt_any && Reset_n) ? gnt_index : '0;
    out_valid_d       = gnt_any || !slot_free;
    out_rgb_d         = gnt_any ? pal_rgb : out_rgb_q;
    out_tag_d         = gnt_any ? gnt_tag : out_tag_q;
    out_src_d         = gnt_any ? gnt_id : out_src_q;
    out_transparent_d = gnt_any ? (pal_rgb == TRANSPARENT_RGB) : out_transparent_q;
    last_grant_d      = gnt_any ? gnt_id : last_grant_q;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_q       <= 1'b0;
      out_rgb_q         <= '0;
      out_tag_q         <= '0;
      out_src_q         <= 1'b0;
      out_transparent_q <= 1'b0;
      last_grant_q      <= 1'b1;
    end else begin
      out_valid_q       <= out_valid_d;
      out_rgb_q         <= out_rgb_d;
      out_tag_q         <= out_tag_d;
      out_src_q         <= out_src_d;
      out_transparent_q <= out_transparent_d;
      last_grant_q      <= last_grant_d;
    end
  end
  assign out_valid       = out_valid_q;
  assign out_rgb         = out_rgb_q;
  assign out_tag         = out_tag_q;
  assign out_src         = out_src_q;
  assign out_transparent = out_transparent_q;
`ifdef PAL_ARB_STATS_EN
  logic [15:0] cnt_p1_q, cnt_p1_d, cnt_p2_q, cnt_p2_d;
  always_comb begin
    cnt_p1_d = stats_clr ? 16'd0 : cnt_p1_q + {15'd0, gnt_any && !gnt_id};
    cnt_p2_d = stats_clr ? 16'd0 : cnt_p2_q + {15'd0, gnt_any && gnt_id};
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_p1_q <= '0;
      cnt_p2_q <= '0;
    end else begin
      cnt_p1_q <= cnt_p1_d;
      cnt_p2_q <= cnt_p2_d;
    end
  end
  assign grant_cnt_p1 = cnt_p1_q;
  assign grant_cnt_p2 = cnt_p2_q;
`endif
endmodule
